// File: rtl/fpu_host_if.sv
// Byte-serial host responder for the FPU pin set: collects opcode + two operands,
// issues them to the core, then streams the result and flags back a byte per read.
//
// state | meaning
// IDLE  | collecting opcode (cnt=0) and operand bytes (cnt=1..8)
// ISSUE | one-cycle core_start pulse
// WAIT  | waiting for core_done
// SEND  | presenting result bytes 0..3 then flags on uo_out, advanced by rd
module fpu_host_if (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [7:0]  ui_in,
   input  logic [7:0]  uio_in,
   output logic [7:0]  uo_out,
   output logic [7:0]  uio_out,
   output logic [7:0]  uio_oe,
   output logic        core_start,
   output logic [2:0]  core_op,
   output logic [31:0] core_a,
   output logic [31:0] core_b,
   input  logic        core_done,
   input  logic [31:0] core_result,
   input  logic [4:0]  core_flags
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_SEND} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [2:0]  idx_q;
   logic        err_q;
   logic        wr_prev_q;
   logic        rd_prev_q;
   logic [2:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] res_q;
   logic [4:0]  flags_q;

   logic       wr_ev;
   logic       rd_ev;
   logic [1:0] byte_sel;
   logic       unused_bits;

   assign wr_ev = ena & uio_in[0] & ~wr_prev_q;
   assign rd_ev = ena & uio_in[1] & ~rd_prev_q;
   // cnt 1..4 and 5..8 both map to byte lanes 0..3 via the low two bits minus one
   assign byte_sel = cnt_q[1:0] - 2'd1;
   assign unused_bits = ^uio_in[7:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= 3'd0;
         err_q     <= 1'b0;
         wr_prev_q <= 1'b0;
         rd_prev_q <= 1'b0;
         op_q      <= 3'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         res_q     <= 32'd0;
         flags_q   <= 5'd0;
      end else if (ena) begin
         wr_prev_q <= uio_in[0];
         rd_prev_q <= uio_in[1];
         unique case (state_q)
            S_IDLE: begin
               if (wr_ev) begin
                  if (cnt_q == 4'd0) begin
                     if (|ui_in[7:3]) begin
                        err_q <= 1'b1;
                     end else begin
                        op_q  <= ui_in[2:0];
                        err_q <= 1'b0;
                        cnt_q <= 4'd1;
                     end
                  end else begin
                     if (cnt_q <= 4'd4) a_q[{byte_sel, 3'b000} +: 8] <= ui_in;
                     else               b_q[{byte_sel, 3'b000} +: 8] <= ui_in;
                     if (cnt_q == 4'd8) begin
                        cnt_q   <= 4'd0;
                        state_q <= S_ISSUE;
                     end else begin
                        cnt_q <= cnt_q + 4'd1;
                     end
                  end
               end
            end
            S_ISSUE, S_WAIT: begin
               if (wr_ev) err_q <= 1'b1;
               if (core_done) begin
                  res_q   <= core_result;
                  flags_q <= core_flags;
                  idx_q   <= 3'd0;
                  state_q <= S_SEND;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_SEND: begin
               if (wr_ev) err_q <= 1'b1;
               if (rd_ev) begin
                  if (idx_q == 3'd4) begin
                     idx_q   <= 3'd0;
                     state_q <= S_IDLE;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      uo_out = 8'h00;
      if (state_q == S_SEND) begin
         if (idx_q[2]) uo_out = {3'b000, flags_q};
         else          uo_out = res_q[{idx_q[1:0], 3'b000} +: 8];
      end
   end

   assign uio_out    = {1'b0, err_q, (state_q == S_SEND), (state_q != S_IDLE), 4'b0000};
   assign uio_oe     = 8'hF0;
   assign core_start = (state_q == S_ISSUE);
   assign core_op    = op_q;
   assign core_a     = a_q;
   assign core_b     = b_q;

endmodule

// File: tb/tb_fpu_host_if.sv
// Bench for fpu_host_if: table of transactions driven byte-serially, with a
// scoreboard for issued operands and returned bytes, plus reset/abuse sequences.
module tb_fpu_host_if;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b1;
   logic [7:0]  ui_in = 8'h00;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [7:0]  uio_in;
   logic [7:0]  uo_out;
   logic [7:0]  uio_out;
   logic [7:0]  uio_oe;
   logic        core_start;
   logic [2:0]  core_op;
   logic [31:0] core_a;
   logic [31:0] core_b;
   logic        core_done = 1'b0;
   logic [31:0] core_result = 32'h0;
   logic [4:0]  core_flags = 5'h0;

   // upper bits carry junk the DUT must ignore
   assign uio_in = {6'b110011, rd, wr};

   always #5 clk = ~clk;

   fpu_host_if dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
      .core_start(core_start), .core_op(core_op), .core_a(core_a), .core_b(core_b),
      .core_done(core_done), .core_result(core_result), .core_flags(core_flags)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
   } txn_t;

   txn_t        vec[4];
   logic [66:0] issue_q[$];
   logic [7:0]  rd_q[$];
   int          checks = 0;
   int          errors = 0;
   int          n_start = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] b);
      ui_in = b;
      wr = 1'b1;
      step();
      wr = 1'b0;
      step();
   endtask

   always @(negedge clk) begin
      if (core_start) begin
         n_start++;
         if (issue_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got op=%0h a=%0h b=%0h expected no pulse",
                     core_op, core_a, core_b);
         end else begin
            chk("issue_operands", {core_op, core_a, core_b}, issue_q.pop_front());
         end
      end
   end

   task automatic run_txn(input int k, input bit hold_op, input bit abuse, input bit ena_gap);
      txn_t       t;
      logic [7:0] bytes[9];
      logic [7:0] exp;
      t = vec[k];
      issue_q.push_back({t.op, t.a, t.b});
      for (int i = 0; i < 4; i++) rd_q.push_back(t.res[8*i +: 8]);
      rd_q.push_back({3'b000, t.flg});
      bytes[0] = {5'b00000, t.op};
      for (int i = 0; i < 4; i++) begin
         bytes[1+i] = t.a[8*i +: 8];
         bytes[5+i] = t.b[8*i +: 8];
      end

      if (hold_op) begin
         ui_in = bytes[0];
         wr = 1'b1;
         repeat (5) step();
         wr = 1'b0;
         step();
      end else begin
         wr_byte(bytes[0]);
      end
      chk("err_cleared_by_opcode", uio_out[6], 1'b0);
      for (int i = 1; i < 8; i++) wr_byte(bytes[i]);

      ui_in = bytes[8];
      wr = 1'b1;
      step();
      chk("start_after_9th", core_start, 1'b1);
      chk("busy_in_issue", uio_out[5:4], 2'b01);
      wr = 1'b0;
      if (t.lat == 0) begin
         core_done = 1'b1; core_result = t.res; core_flags = t.flg;
         step();
         core_done = 1'b0; core_result = 32'h0; core_flags = 5'h0;
      end else begin
         step();
         chk("wait_state", uio_out[5:4], 2'b01);
         chk("start_single_cycle", core_start, 1'b0);
         if (abuse) begin
            wr_byte(8'hEE);
            chk("err_wr_in_wait", uio_out[6], 1'b1);
            chk("a_kept", core_a, t.a);
            chk("b_kept", core_b, t.b);
            chk("still_waiting", uio_out[5:4], 2'b01);
         end
         repeat (t.lat - 1) step();
         core_done = 1'b1; core_result = t.res; core_flags = t.flg;
         step();
         core_done = 1'b0; core_result = 32'h0; core_flags = 5'h0;
      end
      chk("rdy_after_done", uio_out[5:4], 2'b11);
      chk("no_start_in_send", core_start, 1'b0);

      for (int i = 0; i < 5; i++) begin
         exp = rd_q.pop_front();
         chk("read_byte", uo_out, exp);
         if (ena_gap && i == 1) begin
            ena = 1'b0;
            repeat (3) begin
               rd = 1'b1; step();
               rd = 1'b0; step();
            end
            wr_byte(8'h55);
            chk("ena0_idx_held", uo_out, exp);
            chk("ena0_err_held", uio_out[6], 1'b0);
            ena = 1'b1;
         end
         rd = 1'b1; step();
         rd = 1'b0; step();
      end
      chk("idle_after_reads", uio_out, abuse ? 8'h40 : 8'h00);
      chk("uo_zero_idle", uo_out, 8'h00);
   endtask

   initial begin
      int ns;
      vec[0] = '{op: 3'd1, a: 32'h3F80_0000, b: 32'h4000_0000, res: 32'h4040_0000, flg: 5'h01, lat: 3};
      vec[1] = '{op: 3'd2, a: 32'h1234_5678, b: 32'h9ABC_DEF0, res: 32'hDEAD_BEEF, flg: 5'h1F, lat: 0};
      vec[2] = '{op: 3'd7, a: 32'hFFFF_FFFF, b: 32'h0000_0000, res: 32'h8000_0001, flg: 5'h10, lat: 1};
      vec[3] = '{op: 3'd0, a: 32'h0000_0000, b: 32'h0000_0001, res: 32'hA5A5_A5A5, flg: 5'h0A, lat: 5};

      repeat (3) step();
      chk("rst_uo_out", uo_out, 8'h00);
      chk("rst_uio_out", uio_out, 8'h00);
      chk("rst_uio_oe", uio_oe, 8'hF0);
      chk("rst_core_start", core_start, 1'b0);
      chk("rst_core_regs", {core_op, core_a, core_b}, 67'h0);
      rst_n = 1'b1;
      step();

      run_txn(0, 1'b0, 1'b0, 1'b0);

      wr_byte(8'h88);
      chk("bad_opcode_err", uio_out[6], 1'b1);
      chk("bad_opcode_idle", uio_out[5:4], 2'b00);
      chk("bad_opcode_op_kept", core_op, 3'd1);
      run_txn(1, 1'b0, 1'b0, 1'b0);

      run_txn(2, 1'b1, 1'b0, 1'b0);
      run_txn(3, 1'b0, 1'b1, 1'b0);
      run_txn(0, 1'b0, 1'b0, 1'b1);

      ns = n_start;
      wr_byte(8'h05);
      wr_byte(8'hAA);
      wr_byte(8'hBB);
      rst_n = 1'b0;
      #1;
      chk("midrst_uo_out", uo_out, 8'h00);
      chk("midrst_uio_out", uio_out, 8'h00);
      chk("midrst_uio_oe", uio_oe, 8'hF0);
      chk("midrst_core_regs", {core_op, core_a, core_b}, 67'h0);
      step();
      rst_n = 1'b1;
      step();
      core_done = 1'b1; core_result = 32'h1111_1111;
      step();
      core_done = 1'b0; core_result = 32'h0;
      step();
      chk("stray_done_ignored", uio_out, 8'h00);
      chk("midrst_no_start", n_start, ns);
      run_txn(2, 1'b0, 1'b0, 1'b0);

      repeat (2) step();
      chk("all_issues_seen", issue_q.size(), 0);
      chk("start_count", n_start, 6);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
